regfile_wb: RTL and testbench

- Register file and writeback stage for the CPU datapath. Produces the qa/qb operands that feed the ALU operand-select logic.
- Accepts a writeback request each cycle: ALU result or memory load data, a destination register number, and a write enable.
- Registers the request in a one-entry writeback buffer, then commits it to a 32x32 register file on the following edge.
- r0 is hardwired to zero.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/regfile_array.sv | 36 +++
 rtl/regfile_wb.sv | 73 +++++++
 tb/tb_regfile_wb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the register file / writeback slice.
package cpu_pkg;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NREGS = 2 ** AW;

  typedef logic [DW-1:0] word_t;
  typedef logic [AW-1:0] regnum_t;

  localparam regnum_t REG_ZERO = 5'd0;

endpackage : cpu_pkg

// File: rtl/regfile_array.sv
// 32x32 register storage: one synchronous write port, two combinational read
// ports, with r0 hardwired to zero.
module regfile_array
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    we_i,
  input  regnum_t wn_i,
  input  word_t   wd_i,
  input  regnum_t rna_i,
  input  regnum_t rnb_i,
  output word_t   qa_o,
  output word_t   qb_o
);

  word_t regs_q [NREGS];

  // NOTE: the array is reset on purpose; the architecture requires r1..r31
  // to read zero after reset, so this cannot map to a plain RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wn_i != REG_ZERO)) begin
      regs_q[wn_i] <= wd_i;
    end
  end

  // Entry 0 is never written, but the zero rule is enforced here as well so
  // r0 reads zero no matter what the storage holds.
  assign qa_o = (rna_i == REG_ZERO) ? '0 : regs_q[rna_i];
  assign qb_o = (rnb_i == REG_ZERO) ? '0 : regs_q[rnb_i];

endmodule : regfile_array

// File: rtl/regfile_wb.sv
// Writeback stage: one-entry writeback buffer feeding the register file.
// Optional macro REGFILE_BYPASS_EN forwards the pending write to the read ports.
module regfile_wb
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    wreg,
  input  logic    m2reg,
  input  regnum_t wn,
  input  word_t   alu_r,
  input  word_t   mem_d,
  input  regnum_t rna,
  input  regnum_t rnb,
  output word_t   qa,
  output word_t   qb,
  output logic    wb_valid,
  output regnum_t wb_rn,
  output word_t   wb_d
);

  logic    wb_valid_q, wb_valid_d;
  regnum_t wb_rn_q,    wb_rn_d;
  word_t   wb_d_q,     wb_d_d;
  word_t   arr_qa,     arr_qb;

  // Writes aimed at r0 are dropped here so they never occupy the buffer.
  always_comb begin
    wb_valid_d = wreg && (wn != REG_ZERO);
    wb_rn_d    = wn;
    wb_d_d     = m2reg ? mem_d : alu_r;
  end

  // NOTE: sequential state uses non-blocking assignments only, so capture and
  // commit on the same edge both see the pre-edge buffer contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_rn_q    <= '0;
      wb_d_q     <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rn_q    <= wb_rn_d;
      wb_d_q     <= wb_d_d;
    end
  end

  regfile_array u_array (
    .clk   (clk),
    .rst   (rst),
    .we_i  (wb_valid_q),
    .wn_i  (wb_rn_q),
    .wd_i  (wb_d_q),
    .rna_i (rna),
    .rnb_i (rnb),
    .qa_o  (arr_qa),
    .qb_o  (arr_qb)
  );

`ifdef REGFILE_BYPASS_EN
  // A valid buffer never targets r0, so the zero rule keeps priority.
  assign qa = (wb_valid_q && (rna == wb_rn_q)) ? wb_d_q : arr_qa;
  assign qb = (wb_valid_q && (rnb == wb_rn_q)) ? wb_d_q : arr_qb;
`else
  assign qa = arr_qa;
  assign qb = arr_qb;
`endif

  assign wb_valid = wb_valid_q;
  assign wb_rn    = wb_rn_q;
  assign wb_d     = wb_d_q;

endmodule : regfile_wb

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus randomized
// traffic against an architectural model of registers and the pending write.
module tb_regfile_wb;
  import cpu_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  logic    wreg, m2reg;
  regnum_t wn, rna, rnb;
  word_t   alu_r, mem_d;
  word_t   qa, qb, wb_d;
  logic    wb_valid;
  regnum_t wb_rn;

  regfile_wb dut (
    .clk      (clk),
    .rst      (rst),
    .wreg     (wreg),
    .m2reg    (m2reg),
    .wn       (wn),
    .alu_r    (alu_r),
    .mem_d    (mem_d),
    .rna      (rna),
    .rnb      (rnb),
    .qa       (qa),
    .qb       (qb),
    .wb_valid (wb_valid),
    .wb_rn    (wb_rn),
    .wb_d     (wb_d)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register contents plus the one write
  // that has been accepted but not yet committed.
  word_t   ref_regs [NREGS];
  logic    pend_v;
  regnum_t pend_rn;
  word_t   pend_d;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t exp_read(input regnum_t rn);
    if (rn == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (pend_v && rn == pend_rn) return pend_d;
`endif
    return ref_regs[rn];
  endfunction

  task automatic model_reset();
    foreach (ref_regs[i]) ref_regs[i] = '0;
    pend_v  = 1'b0;
    pend_rn = '0;
    pend_d  = '0;
  endtask

  task automatic drive(input logic w, input logic m, input regnum_t n,
                       input word_t a, input word_t md);
    wreg = w; m2reg = m; wn = n; alu_r = a; mem_d = md;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".qa"}, qa, exp_read(rna));
    check({tag, ".qb"}, qb, exp_read(rnb));
    check({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, pend_v});
    check({tag, ".wb_rn"}, {27'd0, wb_rn}, {27'd0, pend_rn});
    check({tag, ".wb_d"}, wb_d, pend_d);
  endtask

  // One clock: apply the architectural rules to the inputs held at the edge,
  // then compare every output a little after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (pend_v) ref_regs[pend_rn] = pend_d;
    pend_v  = wreg && (wn != 0);
    pend_rn = wn;
    pend_d  = m2reg ? mem_d : alu_r;
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    rna = 5'd5; rnb = 5'd31;
    #2;
    check_all("reset");
    #10 rst = 1'b0;                       // released mid-cycle

    // ALU writeback to r3.
    drive(1'b1, 1'b0, 5'd3, 32'h0000_1234, 32'h5555_0000);
    rna = 5'd3; rnb = 5'd3;
    tick("alu_n");
    check("alu_n.wb_d_lit", wb_d, 32'h0000_1234);
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    tick("alu_n1");
    check("alu_n1.qa_lit", qa, 32'h0000_1234);

    // Load writeback to r31 selects mem_d.
    drive(1'b1, 1'b1, 5'd31, 32'h0000_0001, 32'hDEAD_BEEF);
    rna = 5'd31; rnb = 5'd31;
    tick("load_n");
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    tick("load_n1");
    check("load.qb_lit", qb, 32'hDEAD_BEEF);

    // r0 protection.
    drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rna = 5'd0; rnb = 5'd0;
    for (int i = 0; i < 3; i++) tick("r0_wr");
    check("r0.qa_lit", qa, 32'h0);

    // Same-register back-to-back writes, then a different register.
    rna = 5'd7; rnb = 5'd8;
    drive(1'b1, 1'b0, 5'd7, 32'h11, '0);
    tick("b2b_1");
    drive(1'b1, 1'b0, 5'd7, 32'h22, '0);
    tick("b2b_2");
    drive(1'b1, 1'b0, 5'd8, 32'h33, '0);
    tick("b2b_3");
    drive(1'b0, 1'b0, 5'd8, 32'h99, '0);
    for (int i = 0; i < 3; i++) tick("b2b_idle");
    check("b2b.r7_lit", qa, 32'h22);
    check("b2b.r8_lit", qb, 32'h33);

    // Bypass visibility of the pending write to r9.
    rna = 5'd9; rnb = 5'd9;
    drive(1'b1, 1'b0, 5'd9, 32'hABCD, '0);
    tick("byp_n");
`ifdef REGFILE_BYPASS_EN
    check("byp_n.qa_lit", qa, 32'hABCD);
`else
    check("byp_n.qa_lit", qa, 32'h0);
`endif
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    tick("byp_n1");

    // Reset while a write to r5 is pending: it must be discarded.
    rna = 5'd5; rnb = 5'd9;
    drive(1'b1, 1'b0, 5'd5, 32'h5555_5555, '0);
    tick("rst_pend");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    #2 rst = 1'b0;
    tick("rst_after");
    tick("rst_after2");
    check("rst.r5_lit", qa, 32'h0);

    // Randomized traffic focused on a few registers to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            regnum_t'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                  : $urandom_range(0, 5)),
            word_t'($urandom), word_t'($urandom));
      rna = regnum_t'($urandom_range(0, 6));
      rnb = ($urandom_range(0, 1) != 0) ? wn : regnum_t'($urandom_range(0, 31));
      tick("rand");
    end

    // Final sweep of the whole register file.
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    tick("sweep_drain");
    for (int r = 0; r < NREGS; r++) begin
      rna = regnum_t'(r);
      rnb = regnum_t'(NREGS - 1 - r);
      #1;
      check_all("sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_wb
